// File: rtl/branch_control.sv
// Next-PC command generator: resolves branch/call/ret against the flag register and a
// circular return-address stack, issuing one registered command per accepted instruction.
module branch_control #(
  parameter int unsigned RAS_DEPTH = 8,
  parameter int unsigned PTR_W     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [3:0]  br_op,
  input  logic [31:0] rs_value,
  input  logic [25:0] target_in,
  input  logic [31:0] pc_in,
  input  logic        flag_we,
  input  logic [3:0]  flags_in,
  output logic [3:0]  pc_control,
  output logic [25:0] jump_address,
  output logic [31:0] reg_address,
  output logic [3:0]  flags,
  output logic        ras_err,
  output logic        halted
);

  typedef enum logic [1:0] {StIdle, StIssue, StHalt} state_e;

  localparam logic [PTR_W:0] CountFull = (PTR_W+1)'(RAS_DEPTH);

  state_e            state_q, state_d;
  logic [3:0]        pc_control_q, pc_control_d;
  logic [25:0]       jump_q, jump_d;
  logic [31:0]       reg_q, reg_d;
  logic [3:0]        flags_q;
  logic              ras_err_q, ras_err_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d, top_idx;
  logic [PTR_W:0]    count_q, count_d;
  logic [31:0]       ras_q [RAS_DEPTH];
  logic              push, cond;

  // ptr_q names the next free slot, so the newest entry sits one below it.
  assign top_idx = ptr_q - PTR_W'(1);

  always_comb begin
    unique case (br_op)
      4'd3:    cond = rs_value[31];
      4'd4:    cond = (rs_value == 32'd0);
      4'd5:    cond = (rs_value != 32'd0);
      4'd6:    cond = flags_q[3];
      4'd7:    cond = ~flags_q[3];
      4'd8:    cond = flags_q[1];
      4'd9:    cond = ~flags_q[1];
      4'd10:   cond = flags_q[0];
      4'd11:   cond = ~flags_q[0];
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_control_d = 4'd3;
    jump_d       = jump_q;
    reg_d        = reg_q;
    ras_err_d    = ras_err_q;
    ptr_d        = ptr_q;
    count_d      = count_q;
    push         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (instr_valid) begin
          state_d      = StIssue;
          pc_control_d = 4'd0;
          unique case (br_op)
            4'd1: begin
              pc_control_d = 4'd1;
              jump_d       = target_in;
            end
            4'd2: begin
              pc_control_d = 4'd2;
              reg_d        = rs_value;
            end
            4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11: begin
              if (cond) begin
                pc_control_d = 4'd1;
                jump_d       = target_in;
              end
            end
            4'd12: begin
              push         = 1'b1;
              pc_control_d = 4'd1;
              jump_d       = target_in;
              ptr_d        = ptr_q + PTR_W'(1);
              if (count_q == CountFull) ras_err_d = 1'b1;
              else                      count_d   = count_q + 1'b1;
            end
            4'd13: begin
              pc_control_d = 4'd2;
              if (count_q == '0) begin
                reg_d     = 32'd0;
                ras_err_d = 1'b1;
              end else begin
                reg_d   = ras_q[top_idx];
                ptr_d   = top_idx;
                count_d = count_q - 1'b1;
              end
            end
            4'd14: begin
              state_d      = StHalt;
              pc_control_d = 4'd3;
            end
            default: pc_control_d = 4'd0;
          endcase
        end
      end
      StIssue: state_d = StIdle;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      pc_control_q <= 4'd3;
      jump_q       <= '0;
      reg_q        <= '0;
      flags_q      <= '0;
      ras_err_q    <= 1'b0;
      ptr_q        <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_control_q <= pc_control_d;
      jump_q       <= jump_d;
      reg_q        <= reg_d;
      ras_err_q    <= ras_err_d;
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      if (flag_we) flags_q <= flags_in;
    end
  end

  // Stack contents need no reset; count_q gates every read.
  always_ff @(posedge clk) begin
    if (push) ras_q[ptr_q] <= pc_in + 32'd4;
  end

  assign instr_ready  = (state_q == StIdle);
  assign halted       = (state_q == StHalt);
  assign pc_control   = pc_control_q;
  assign jump_address = jump_q;
  assign reg_address  = reg_q;
  assign flags        = flags_q;
  assign ras_err      = ras_err_q;

endmodule

// File: tb/tb_branch_control.sv
// Bench for branch_control: directed scenarios plus random traffic, all checked each cycle
// against a queue-based behavioural model.
module tb_branch_control;

  localparam int Depth = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  br_op = '0;
  logic [31:0] rs_value = '0;
  logic [25:0] target_in = '0;
  logic [31:0] pc_in = '0;
  logic        flag_we = 1'b0;
  logic [3:0]  flags_in = '0;
  logic [3:0]  pc_control;
  logic [25:0] jump_address;
  logic [31:0] reg_address;
  logic [3:0]  flags;
  logic        ras_err;
  logic        halted;

  branch_control #(.RAS_DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .br_op(br_op), .rs_value(rs_value), .target_in(target_in), .pc_in(pc_in),
    .flag_we(flag_we), .flags_in(flags_in), .pc_control(pc_control),
    .jump_address(jump_address), .reg_address(reg_address), .flags(flags),
    .ras_err(ras_err), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model
  logic [3:0]  m_pc;
  logic [25:0] m_jump;
  logic [31:0] m_reg;
  logic [3:0]  m_flags;
  logic        m_err, m_halted, m_busy;
  logic [31:0] m_ras [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 4'd3; m_jump = '0; m_reg = '0; m_flags = '0;
    m_err = 1'b0; m_halted = 1'b0; m_busy = 1'b0;
    m_ras.delete();
  endtask

  task automatic compare_all();
    chk("pc_control", {28'd0, pc_control}, {28'd0, m_pc});
    chk("jump_address", {6'd0, jump_address}, {6'd0, m_jump});
    chk("reg_address", reg_address, m_reg);
    chk("flags", {28'd0, flags}, {28'd0, m_flags});
    chk("ras_err", {31'd0, ras_err}, {31'd0, m_err});
    chk("halted", {31'd0, halted}, {31'd0, m_halted});
    chk("instr_ready", {31'd0, instr_ready}, {31'd0, !m_halted && !m_busy});
  endtask

  // One clock: model consumes the current inputs, then outputs are compared after the edge.
  task automatic step();
    logic        acc, taken;
    logic [3:0]  n_pc;
    logic [25:0] n_jump;
    logic [31:0] n_reg;
    acc = instr_valid && !m_halted && !m_busy;
    n_pc = 4'd3; n_jump = m_jump; n_reg = m_reg;
    if (acc) begin
      taken = 1'b0;
      case (br_op)
        4'd3:  taken = rs_value[31];
        4'd4:  taken = (rs_value == 0);
        4'd5:  taken = (rs_value != 0);
        4'd6:  taken = m_flags[3];
        4'd7:  taken = !m_flags[3];
        4'd8:  taken = m_flags[1];
        4'd9:  taken = !m_flags[1];
        4'd10: taken = m_flags[0];
        4'd11: taken = !m_flags[0];
        default: taken = 1'b0;
      endcase
      if (br_op == 4'd1 || br_op == 4'd12 || taken) begin
        n_pc = 4'd1; n_jump = target_in;
      end else if (br_op == 4'd2) begin
        n_pc = 4'd2; n_reg = rs_value;
      end else if (br_op == 4'd13) begin
        n_pc = 4'd2;
        if (m_ras.size() == 0) begin
          n_reg = 32'd0; m_err = 1'b1;
        end else begin
          n_reg = m_ras.pop_back();
        end
      end else if (br_op != 4'd14) begin
        n_pc = 4'd0;
      end
      if (br_op == 4'd12) begin
        m_ras.push_back(pc_in + 32'd4);
        if (m_ras.size() > Depth) begin
          void'(m_ras.pop_front());
          m_err = 1'b1;
        end
      end
    end
    @(posedge clk) #1;
    if (flag_we) m_flags = flags_in;
    m_pc = n_pc; m_jump = n_jump; m_reg = n_reg;
    m_busy = acc && (br_op != 4'd14);
    if (acc && br_op == 4'd14) m_halted = 1'b1;
    compare_all();
  endtask

  // Called at posedge+1; reset lands mid-cycle and is checked before any clock edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    compare_all();
    @(posedge clk) #1 rst = 1'b0;
    compare_all();
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [25:0] tgt,
                       input logic [31:0] pc);
    instr_valid = 1'b1; br_op = op; rs_value = rs; target_in = tgt; pc_in = pc;
    step();
    instr_valid = 1'b0; flag_we = 1'b0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    #3;
    compare_all();
    @(posedge clk) #1 rst = 1'b0;

    // T1: async reset discards a pending command
    issue(4'd1, 0, 26'd7, 0);
    chk("t1_pending_pc", {28'd0, pc_control}, 32'd1);
    do_reset();
    chk("t1_pc", {28'd0, pc_control}, 32'd3);
    chk("t1_jump", {6'd0, jump_address}, 32'd0);
    chk("t1_ready", {31'd0, instr_ready}, 32'd1);
    chk("t1_halted", {31'd0, halted}, 32'd0);

    // T2: unconditional branch
    issue(4'd1, 0, 26'd5, 0);
    chk("t2_pc", {28'd0, pc_control}, 32'd1);
    chk("t2_jump", {6'd0, jump_address}, 32'd5);
    step();
    chk("t2_hold", {28'd0, pc_control}, 32'd3);
    chk("t2_ready", {31'd0, instr_ready}, 32'd1);

    // T3: flag-conditioned branches see the pre-write flags
    flag_we = 1'b1; flags_in = 4'b1000;
    step();
    flag_we = 1'b0;
    chk("t3_flags", {28'd0, flags}, 32'h8);
    issue(4'd6, 0, 26'd9, 0);
    chk("t3_bcy", {28'd0, pc_control}, 32'd1);
    step();
    issue(4'd7, 0, 26'd9, 0);
    chk("t3_bncy", {28'd0, pc_control}, 32'd0);
    step();
    flag_we = 1'b1; flags_in = 4'b0000;
    issue(4'd6, 0, 26'd9, 0);
    chk("t3_bcy_old", {28'd0, pc_control}, 32'd1);
    chk("t3_flags_new", {28'd0, flags}, 32'h0);
    step();

    // T4: register branches
    issue(4'd2, 32'd31, 0, 0);
    chk("t4_br_pc", {28'd0, pc_control}, 32'd2);
    chk("t4_br_reg", reg_address, 32'd31);
    step();
    issue(4'd4, 32'd0, 26'd3, 0);
    chk("t4_bz0", {28'd0, pc_control}, 32'd1);
    step();
    issue(4'd4, 32'd7, 26'd3, 0);
    chk("t4_bz7", {28'd0, pc_control}, 32'd0);
    step();
    issue(4'd3, 32'h8000_0000, 26'd3, 0);
    chk("t4_bltz", {28'd0, pc_control}, 32'd1);
    step();

    // T5: return-address stack
    do_reset();
    issue(4'd12, 0, 26'd1, 32'h100); step();
    issue(4'd12, 0, 26'd2, 32'h200); step();
    issue(4'd13, 0, 0, 0);
    chk("t5_ret1", reg_address, 32'h204);
    chk("t5_model_ret1", m_reg, 32'h204);
    step();
    issue(4'd13, 0, 0, 0);
    chk("t5_ret2", reg_address, 32'h104);
    chk("t5_err_clear", {31'd0, ras_err}, 32'd0);
    step();
    issue(4'd13, 0, 0, 0);
    chk("t5_ret3", reg_address, 32'd0);
    chk("t5_ret3_pc", {28'd0, pc_control}, 32'd2);
    chk("t5_err", {31'd0, ras_err}, 32'd1);
    step();
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      issue(4'd12, 0, 26'd1, 32'(i * 16));
      chk("t5_err_flag", {31'd0, ras_err}, (i == 9) ? 32'd1 : 32'd0);
      step();
    end
    issue(4'd13, 0, 0, 0);
    chk("t5_ret_9th", reg_address, 32'h94);
    step();
    for (int i = 0; i < 8; i++) begin
      issue(4'd13, 0, 0, 0);
      step();
    end
    chk("t5_model_wrapped", {31'd0, m_err}, 32'd1);

    // T6: halt is terminal until reset; flags still update
    issue(4'd14, 0, 0, 0);
    instr_valid = 1'b1; br_op = 4'd1;
    for (int i = 0; i < 20; i++) begin
      flag_we = (i == 10); flags_in = 4'b0101;
      step();
      chk("t6_pc", {28'd0, pc_control}, 32'd3);
      chk("t6_halted", {31'd0, halted}, 32'd1);
    end
    flag_we = 1'b0;
    instr_valid = 1'b0;
    chk("t6_flags", {28'd0, flags}, 32'h5);
    do_reset();
    chk("t6_ready", {31'd0, instr_ready}, 32'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      instr_valid = ($urandom_range(0, 3) != 0);
      br_op = 4'($urandom_range(0, 15));
      if (br_op == 4'd14) br_op = 4'd13;
      case ($urandom_range(0, 3))
        0:       rs_value = 32'd0;
        1:       rs_value = 32'h8000_0000 | $urandom;
        default: rs_value = $urandom;
      endcase
      target_in = 26'($urandom);
      pc_in = $urandom;
      flag_we = ($urandom_range(0, 3) == 0);
      flags_in = 4'($urandom);
      if ($urandom_range(0, 299) == 0) do_reset();
      else step();
    end
    instr_valid = 1'b0; flag_we = 1'b0;
    issue(4'd14, 0, 0, 0);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
